// File: rtl/clk_gate_ctrl_if.sv
// rtl/clk_gate_ctrl_if.sv - request/enable bundle between domain logic and the ICG sequencer
// Purpose: groups the per-domain request/activity inputs and the ICG enable/ack outputs.
// Signals:
//   req      [N_DOM] per-domain clock request, level
//   busy     [N_DOM] per-domain activity, keeps an already running clock on
//   te               scan/test enable, freezes the sequencer
//   force_on [N_DOM] permanent request per domain (CLKGATE_FORCE_ON_EN only)
//   e        [N_DOM] ICG enable per domain
//   ack      [N_DOM] domain clock running and stable
//   all_off          every domain is off
// Modports: master drives requests, slave is the sequencer.
interface clk_gate_ctrl_if #(
  parameter int N_DOM = 4
);
  logic [N_DOM-1:0] req;
  logic [N_DOM-1:0] busy;
  logic             te;
`ifdef CLKGATE_FORCE_ON_EN
  logic [N_DOM-1:0] force_on;
`endif
  logic [N_DOM-1:0] e;
  logic [N_DOM-1:0] ack;
  logic             all_off;

`ifdef CLKGATE_FORCE_ON_EN
  modport master (output req, busy, te, force_on, input e, ack, all_off);
  modport slave  (input req, busy, te, force_on, output e, ack, all_off);
`else
  modport master (output req, busy, te, input e, ack, all_off);
  modport slave  (input req, busy, te, output e, ack, all_off);
`endif
endinterface

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - per-domain ICG enable sequencer with wake settling and idle shut-off
// Purpose: one independent OFF/WAKE/ON/IDLE FSM per gated domain driving the ICG E pins.
// Ports:
//   clk  in  free-running always-on clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of clk_gate_ctrl_if (req, busy, te, [force_on] in; e, ack, all_off out)
// Optional feature macro: CLKGATE_FORCE_ON_EN adds bus.force_on as a permanent request.
module clk_gate_ctrl #(
  parameter int N_DOM       = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  clk_gate_ctrl_if.slave   bus
);

  localparam int MAXC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  state_t           state_q [N_DOM];
  state_t           state_d [N_DOM];
  logic [CW-1:0]    cnt_q   [N_DOM];
  logic [CW-1:0]    cnt_d   [N_DOM];
  logic [N_DOM-1:0] e_d;
  logic [N_DOM-1:0] ack_d;
  logic             all_off_d;
  logic [N_DOM-1:0] wake;
  logic [N_DOM-1:0] keep;

  // busy alone must never start a clock, it only holds one that is running
`ifdef CLKGATE_FORCE_ON_EN
  assign wake = bus.req | bus.force_on;
  assign keep = bus.req | bus.busy | bus.force_on;
`else
  assign wake = bus.req;
  assign keep = bus.req | bus.busy;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_DOM; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      bus.e       <= '0;
      bus.ack     <= '0;
      bus.all_off <= 1'b1;
    end else begin
      for (int i = 0; i < N_DOM; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      bus.e       <= e_d;
      bus.ack     <= ack_d;
      bus.all_off <= all_off_d;
    end
  end

  always_comb begin
    all_off_d = 1'b1;
    e_d       = '0;
    ack_d     = '0;
    for (int i = 0; i < N_DOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // te holds everything: next state equals current, so the outputs hold too
      if (!bus.te) begin
        case (state_q[i])
          ST_OFF: begin
            if (wake[i]) begin
              state_d[i] = ST_WAKE;
              cnt_d[i]   = WAKE_LD;
            end
          end
          ST_WAKE: begin
            if (cnt_q[i] == '0) state_d[i] = ST_ON;
            else                cnt_d[i]   = cnt_q[i] - ONE;
          end
          ST_ON: begin
            if (!keep[i]) begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = IDLE_LD;
            end
          end
          ST_IDLE: begin
            // activity on the expiry edge wins, so E never dips
            if (keep[i])              state_d[i] = ST_ON;
            else if (cnt_q[i] == '0)  state_d[i] = ST_OFF;
            else                      cnt_d[i]   = cnt_q[i] - ONE;
          end
          default: state_d[i] = ST_OFF;
        endcase
      end
      // outputs are decoded from the next state and registered, so E is a clean flop output
      e_d[i]    = (state_d[i] != ST_OFF);
      ack_d[i]  = (state_d[i] == ST_ON) || (state_d[i] == ST_IDLE);
      all_off_d = all_off_d & (state_d[i] == ST_OFF);
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  clk_gate_ctrl_if #(.N_DOM(4)) bus ();

  clk_gate_ctrl #(.N_DOM(4), .IDLE_CYCLES(16), .WAKE_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, land 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL reset_e: got %b want %b", bus.e, 4'b0000); end
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want %b", bus.ack, 4'b0000); end
    total++; if (bus.all_off !== 1'b1) begin bad++; $display("FAIL reset_all_off: got %b want %b", bus.all_off, 1'b1); end
    bus.busy = 4'b1111;
    step(3);
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL busy_no_wake_e: got %b want %b", bus.e, 4'b0000); end
    total++; if (bus.all_off !== 1'b1) begin bad++; $display("FAIL busy_no_wake_all_off: got %b want %b", bus.all_off, 1'b1); end
    bus.busy = 4'b0000;
  endtask

  task automatic test_wake();
    bus.req = 4'b0001;
    step(1);
    total++; if (bus.e !== 4'b0001) begin bad++; $display("FAIL wake_e: got %b want %b", bus.e, 4'b0001); end
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL wake_ack_t0: got %b want %b", bus.ack, 4'b0000); end
    total++; if (bus.all_off !== 1'b0) begin bad++; $display("FAIL wake_all_off: got %b want %b", bus.all_off, 1'b0); end
    step(1);
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL wake_ack_t1: got %b want %b", bus.ack, 4'b0000); end
    step(1);
    total++; if (bus.ack !== 4'b0001) begin bad++; $display("FAIL wake_ack_t2: got %b want %b", bus.ack, 4'b0001); end
    total++; if (bus.e !== 4'b0001) begin bad++; $display("FAIL wake_e_on: got %b want %b", bus.e, 4'b0001); end
  endtask

  task automatic test_idle_off();
    bus.req = 4'b0000;
    step(16);
    total++; if (bus.e !== 4'b0001) begin bad++; $display("FAIL idle_e_t15: got %b want %b", bus.e, 4'b0001); end
    total++; if (bus.ack !== 4'b0001) begin bad++; $display("FAIL idle_ack_t15: got %b want %b", bus.ack, 4'b0001); end
    step(1);
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL idle_e_t16: got %b want %b", bus.e, 4'b0000); end
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL idle_ack_t16: got %b want %b", bus.ack, 4'b0000); end
    total++; if (bus.all_off !== 1'b1) begin bad++; $display("FAIL idle_all_off: got %b want %b", bus.all_off, 1'b1); end
  endtask

  task automatic test_busy_restart();
    bus.req = 4'b0010;
    step(3);
    total++; if (bus.ack !== 4'b0010) begin bad++; $display("FAIL busy_on_ack: got %b want %b", bus.ack, 4'b0010); end
    bus.req = 4'b0000;
    step(5);
    bus.busy = 4'b0010;
    step(1);
    bus.busy = 4'b0000;
    step(16);
    total++; if (bus.e !== 4'b0010) begin bad++; $display("FAIL busy_restart_e_hold: got %b want %b", bus.e, 4'b0010); end
    step(1);
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL busy_restart_e_off: got %b want %b", bus.e, 4'b0000); end
  endtask

  task automatic test_expiry_req();
    bus.req = 4'b0100;
    step(3);
    bus.req = 4'b0000;
    step(16);
    bus.req = 4'b0100;
    step(1);
    total++; if (bus.e !== 4'b0100) begin bad++; $display("FAIL expiry_req_e: got %b want %b", bus.e, 4'b0100); end
    total++; if (bus.ack !== 4'b0100) begin bad++; $display("FAIL expiry_req_ack: got %b want %b", bus.ack, 4'b0100); end
    step(3);
    total++; if (bus.e !== 4'b0100) begin bad++; $display("FAIL expiry_req_e_later: got %b want %b", bus.e, 4'b0100); end
    bus.req = 4'b0000;
    step(17);
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL expiry_req_final_off: got %b want %b", bus.e, 4'b0000); end
  endtask

  task automatic test_back_to_back();
    bus.req = 4'b0001;
    step(3);
    bus.req = 4'b0000;
    step(17);
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL b2b_off_e: got %b want %b", bus.e, 4'b0000); end
    bus.req = 4'b0001;
    step(1);
    total++; if (bus.e !== 4'b0001) begin bad++; $display("FAIL b2b_rewake_e: got %b want %b", bus.e, 4'b0001); end
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL b2b_rewake_ack: got %b want %b", bus.ack, 4'b0000); end
    step(2);
    total++; if (bus.ack !== 4'b0001) begin bad++; $display("FAIL b2b_ack: got %b want %b", bus.ack, 4'b0001); end
    bus.req = 4'b0000;
    step(17);
  endtask

  task automatic test_req_pulse_wake();
    bus.req = 4'b1000;
    step(1);
    total++; if (bus.e !== 4'b1000) begin bad++; $display("FAIL pulse_e: got %b want %b", bus.e, 4'b1000); end
    bus.req = 4'b0000;
    step(1);
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL pulse_ack_t1: got %b want %b", bus.ack, 4'b0000); end
    step(1);
    total++; if (bus.ack !== 4'b1000) begin bad++; $display("FAIL pulse_ack_t2: got %b want %b", bus.ack, 4'b1000); end
    step(16);
    total++; if (bus.e !== 4'b1000) begin bad++; $display("FAIL pulse_e_hold: got %b want %b", bus.e, 4'b1000); end
    step(1);
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL pulse_e_off: got %b want %b", bus.e, 4'b0000); end
  endtask

  task automatic test_te();
    bus.req = 4'b0001;
    step(1);
    bus.te  = 1'b1;
    bus.req = 4'b0000;
    step(8);
    total++; if (bus.e !== 4'b0001) begin bad++; $display("FAIL te_wake_e: got %b want %b", bus.e, 4'b0001); end
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL te_wake_ack: got %b want %b", bus.ack, 4'b0000); end
    bus.te = 1'b0;
    step(1);
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL te_wake_resume_ack0: got %b want %b", bus.ack, 4'b0000); end
    step(1);
    total++; if (bus.ack !== 4'b0001) begin bad++; $display("FAIL te_wake_resume_ack1: got %b want %b", bus.ack, 4'b0001); end
    // now ON with req low: first idle sample on the next edge, then 4 more decrements
    step(5);
    bus.te   = 1'b1;
    bus.req  = 4'b0001;
    bus.busy = 4'b0001;
    step(8);
    total++; if (bus.e !== 4'b0001) begin bad++; $display("FAIL te_idle_e: got %b want %b", bus.e, 4'b0001); end
    total++; if (bus.all_off !== 1'b0) begin bad++; $display("FAIL te_idle_all_off: got %b want %b", bus.all_off, 1'b0); end
    bus.req  = 4'b0000;
    bus.busy = 4'b0000;
    bus.te   = 1'b0;
    step(11);
    total++; if (bus.e !== 4'b0001) begin bad++; $display("FAIL te_idle_resume_hold: got %b want %b", bus.e, 4'b0001); end
    step(1);
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL te_idle_resume_off: got %b want %b", bus.e, 4'b0000); end
    total++; if (bus.all_off !== 1'b1) begin bad++; $display("FAIL te_idle_resume_all_off: got %b want %b", bus.all_off, 1'b1); end
  endtask

  task automatic test_multi();
    bus.req = 4'b1010;
    step(1);
    total++; if (bus.e !== 4'b1010) begin bad++; $display("FAIL multi_e: got %b want %b", bus.e, 4'b1010); end
    step(2);
    total++; if (bus.ack !== 4'b1010) begin bad++; $display("FAIL multi_ack: got %b want %b", bus.ack, 4'b1010); end
    bus.req = 4'b0000;
    step(17);
    total++; if (bus.all_off !== 1'b1) begin bad++; $display("FAIL multi_all_off: got %b want %b", bus.all_off, 1'b1); end
  endtask

  task automatic test_rst_mid_on();
    bus.req = 4'b0001;
    step(3);
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL rst_async_e: got %b want %b", bus.e, 4'b0000); end
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL rst_async_ack: got %b want %b", bus.ack, 4'b0000); end
    total++; if (bus.all_off !== 1'b1) begin bad++; $display("FAIL rst_async_all_off: got %b want %b", bus.all_off, 1'b1); end
    bus.req = 4'b0000;
    step(1);
    rst = 1'b0;
    step(3);
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL rst_stay_off: got %b want %b", bus.e, 4'b0000); end
    bus.req = 4'b0001;
    step(1);
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL rst_rewake_ack_t0: got %b want %b", bus.ack, 4'b0000); end
    step(1);
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL rst_rewake_ack_t1: got %b want %b", bus.ack, 4'b0000); end
    step(1);
    total++; if (bus.ack !== 4'b0001) begin bad++; $display("FAIL rst_rewake_ack_t2: got %b want %b", bus.ack, 4'b0001); end
    bus.req = 4'b0000;
    step(17);
  endtask

`ifdef CLKGATE_FORCE_ON_EN
  task automatic test_force_on();
    bus.force_on = 4'b1000;
    step(1);
    total++; if (bus.e !== 4'b1000) begin bad++; $display("FAIL force_e: got %b want %b", bus.e, 4'b1000); end
    step(1);
    total++; if (bus.ack !== 4'b0000) begin bad++; $display("FAIL force_ack_t1: got %b want %b", bus.ack, 4'b0000); end
    step(1);
    total++; if (bus.ack !== 4'b1000) begin bad++; $display("FAIL force_ack_t2: got %b want %b", bus.ack, 4'b1000); end
    step(40);
    total++; if (bus.ack !== 4'b1000) begin bad++; $display("FAIL force_held: got %b want %b", bus.ack, 4'b1000); end
    bus.force_on = 4'b0000;
    step(16);
    total++; if (bus.e !== 4'b1000) begin bad++; $display("FAIL force_release_hold: got %b want %b", bus.e, 4'b1000); end
    step(1);
    total++; if (bus.e !== 4'b0000) begin bad++; $display("FAIL force_release_off: got %b want %b", bus.e, 4'b0000); end
  endtask
`endif

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.req  = 4'b0000;
    bus.busy = 4'b0000;
    bus.te   = 1'b0;
`ifdef CLKGATE_FORCE_ON_EN
    bus.force_on = 4'b0000;
`endif
    step(2);
    rst = 1'b0;
    step(1);
    test_reset();
    test_wake();
    test_idle_off();
    test_busy_restart();
    test_expiry_req();
    test_back_to_back();
    test_req_pulse_wake();
    test_te();
    test_multi();
    test_rst_mid_on();
`ifdef CLKGATE_FORCE_ON_EN
    test_force_on();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
